// File: rtl/tw_seq_pkg.sv
// Shared types and codes for the twiddle-ROM sequencer: FSM states, ROM state codes,
// ROM write-strobe codes and the FSM-to-state-code mapping.
package tw_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL_HI  = 3'd1,
        BURST_HI = 3'd2,
        FILL_LO  = 3'd3,
        BURST_LO = 3'd4,
        RUN      = 3'd5,
        DONE     = 3'd6
    } fsm_e;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_LOAD     = 4'd2;
    localparam logic [3:0] ST_RUN      = 4'd4;
    localparam logic [3:0] ST_RUN_LAST = 4'd6;
    localparam logic [3:0] ST_DONE     = 4'd8;

    localparam logic [1:0] W_NONE = 2'd0;
    localparam logic [1:0] W_HI   = 2'd1;
    localparam logic [1:0] W_LO   = 2'd2;

    // Code presented to the ROM for a given controller state.
    function automatic logic [3:0] state_code(input logic [2:0] s, input logic last_stage);
        logic [3:0] code;
        code = ST_IDLE;
        case (s)
            IDLE:                                 code = ST_IDLE;
            FILL_HI, BURST_HI, FILL_LO, BURST_LO: code = ST_LOAD;
            RUN:                                  code = last_stage ? ST_RUN_LAST : ST_RUN;
            DONE:                                 code = ST_DONE;
            default:                              code = ST_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tw_rom_seq_ctrl_if.sv
// Host load channel of the twiddle-ROM sequencer: 64-bit twiddle halves over valid/ready.
interface tw_rom_seq_ctrl_if #(
    parameter int HDW = 64
) ();

    logic           ld_valid;
    logic [HDW-1:0] ld_data;
    logic           ld_ready;

    modport master (output ld_valid, output ld_data, input  ld_ready);
    modport slave  (input  ld_valid, input  ld_data, output ld_ready);

endinterface

// File: rtl/tw_seq_wbuf.sv
// Four-entry staging buffer for one half of the writable twiddle table: a fill pointer
// advanced by host accepts and a burst read pointer that restarts on any gap in reads.
module tw_seq_wbuf #(
    parameter int HDW       = 64,
    parameter int NUM_ENTRY = 4
) (
    input  logic           CLK,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [HDW-1:0] wr_data,
    input  logic           rd_en,
    output logic [HDW-1:0] rd_data,
    output logic           wr_last,
    output logic           rd_last
);

    localparam int PW = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;

    logic [HDW-1:0] mem [NUM_ENTRY];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;

    assign wr_last = (wptr == PW'(NUM_ENTRY - 1));
    assign rd_last = (rptr == PW'(NUM_ENTRY - 1));
    assign rd_data = mem[rptr];

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wr_last ? '0 : wptr + 1'b1;
            end
            if (!rd_en) begin
                rptr <= '0;
            end else begin
                rptr <= rd_last ? '0 : rptr + 1'b1;
            end
        end
    end

    // NOTE: the data array is deliberately left out of reset; every entry is rewritten
    // before it is read, and a reset here would only cost flops and routing.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wptr] <= wr_data;
        end
    end

endmodule

// File: rtl/tw_rom_seq_ctrl.sv
// Twiddle-ROM sequencer: buffers host halves, replays them as 4-cycle ROM write bursts,
// then steps the NTT stages. Optional perf counter enabled by TW_SEQ_PERF_CNT_EN.
module tw_rom_seq_ctrl
    import tw_seq_pkg::*;
#(
    parameter int SC_WIDTH  = 3,
    parameter int S_WIDTH   = 4,
    parameter int HDW       = 64,
    parameter int NUM_ENTRY = 4,
    parameter int NUM_STAGE = 3,
    parameter int LEN_W     = 16
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                start,
    input  logic                do_load,
    input  logic [LEN_W-1:0]    stage_len,
    tw_rom_seq_ctrl_if.slave    ld_if,
    output logic [1:0]          rom_w,
    output logic [HDW-1:0]      rom_wdata,
    output logic [SC_WIDTH-1:0] stage_counter,
    output logic                CEN,
    output logic [S_WIDTH-1:0]  state,
    output logic                busy,
    output logic                done
`ifdef TW_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]         perf_cycles
`endif
);

    localparam logic [2:0] S_IDLE     = IDLE;
    localparam logic [2:0] S_FILL_HI  = FILL_HI;
    localparam logic [2:0] S_BURST_HI = BURST_HI;
    localparam logic [2:0] S_FILL_LO  = FILL_LO;
    localparam logic [2:0] S_BURST_LO = BURST_LO;
    localparam logic [2:0] S_RUN      = RUN;
    localparam logic [2:0] S_DONE     = DONE;

    logic [2:0]          fsm;
    logic [2:0]          fsm_nxt;
    logic [SC_WIDTH-1:0] sc;
    logic [LEN_W-1:0]    cc;
    logic [LEN_W-1:0]    len_q;
    logic [HDW-1:0]      rd_data;
    logic                start_acc;
    logic                accept;
    logic                burst;
    logic                wr_last;
    logic                rd_last;
    logic                cyc_last;
    logic                stage_last;

    assign start_acc  = (fsm == S_IDLE) && start;
    assign accept     = ld_if.ld_valid && ld_if.ld_ready;
    assign burst      = (fsm == S_BURST_HI) || (fsm == S_BURST_LO);
    assign cyc_last   = (cc == len_q - 1'b1);
    assign stage_last = (sc == SC_WIDTH'(NUM_STAGE - 1));

    tw_seq_wbuf #(
        .HDW       (HDW),
        .NUM_ENTRY (NUM_ENTRY)
    ) u_wbuf (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_data (ld_if.ld_data),
        .rd_en   (burst),
        .rd_data (rd_data),
        .wr_last (wr_last),
        .rd_last (rd_last)
    );

    // NOTE: fsm_nxt gets its hold value first so every path assigns it and no latch
    // is inferred; combinational blocks use blocking '=' throughout.
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            S_IDLE:     if (start)               fsm_nxt = do_load ? S_FILL_HI : S_RUN;
            S_FILL_HI:  if (accept && wr_last)   fsm_nxt = S_BURST_HI;
            S_BURST_HI: if (rd_last)             fsm_nxt = S_FILL_LO;
            S_FILL_LO:  if (accept && wr_last)   fsm_nxt = S_BURST_LO;
            S_BURST_LO: if (rd_last)             fsm_nxt = S_RUN;
            S_RUN:      if (cyc_last && stage_last) fsm_nxt = S_DONE;
            S_DONE:                              fsm_nxt = S_IDLE;
            default:                             fsm_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples the
    // pre-edge values and block ordering cannot change behaviour.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            fsm   <= S_IDLE;
            sc    <= '0;
            cc    <= '0;
            len_q <= LEN_W'(1);
        end else begin
            fsm <= fsm_nxt;
            if (start_acc) begin
                len_q <= (stage_len == '0) ? LEN_W'(1) : stage_len;
                sc    <= '0;
                cc    <= '0;
            end else if (fsm == S_RUN) begin
                if (cyc_last) begin
                    cc <= '0;
                    sc <= stage_last ? '0 : sc + 1'b1;
                end else begin
                    cc <= cc + 1'b1;
                end
            end
        end
    end

    // ROM-facing outputs trail the FSM by one cycle; ld_ready and busy are aligned to the
    // state being entered so the host sees ready in the first FILL cycle.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            ld_if.ld_ready <= 1'b0;
            rom_w          <= W_NONE;
            rom_wdata      <= '0;
            stage_counter  <= '0;
            CEN            <= 1'b1;
            state          <= S_WIDTH'(ST_IDLE);
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            ld_if.ld_ready <= (fsm_nxt == S_FILL_HI) || (fsm_nxt == S_FILL_LO);
            rom_w          <= (fsm == S_BURST_HI) ? W_HI :
                              (fsm == S_BURST_LO) ? W_LO : W_NONE;
            rom_wdata      <= burst ? rd_data : '0;
            stage_counter  <= (fsm == S_RUN) ? sc : '0;
            CEN            <= (fsm != S_RUN);
            state          <= S_WIDTH'(state_code(fsm, stage_last));
            busy           <= (fsm_nxt != S_IDLE) || (fsm == S_DONE);
            done           <= (fsm == S_DONE);
        end
    end

`ifdef TW_SEQ_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if (start_acc) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule
